// File: rtl/gnss_iq_pkg.sv
// Shared types for the GNSS IQ capture path: 2-bit sign/magnitude samples,
// the record byte encoding, and the packer/serializer state enums.
package gnss_iq_pkg;

    typedef struct packed {
        logic sign;
        logic mag;
    } iq_sample_t;

    // One front-end strobe worth of data; I sits in the upper bits.
    typedef struct packed {
        iq_sample_t i;
        iq_sample_t q;
    } iq_pair_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DRAIN
    } packer_state_e;

    typedef enum logic {
        PH_I,
        PH_Q
    } ser_phase_e;

    function automatic logic [7:0] encode(input iq_sample_t s);
        return {6'b0, s.sign, s.mag};
    endfunction

endpackage

// File: rtl/iq_sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty derive from the
// count register so they reflect the state at the start of the cycle.
module iq_sync_fifo #(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are valid, so flushing only needs the control registers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/iq_byte_packer.sv
// Captures len I/Q sample pairs from the front end into a FIFO and serializes
// them as I byte then Q byte per sample over a valid/ready byte stream.
module iq_byte_packer
    import gnss_iq_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LEN_W = 24,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [1:0]       i_in,
    input  logic [1:0]       q_in,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);

    packer_state_e          state, state_nxt;
    logic                   done_nxt;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       wr_cnt;
    logic [LEN_W-1:0]       rd_cnt;

    iq_pair_t               fifo_wdata;
    iq_pair_t               fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count_unused;

    logic                   start_ok;
    logic                   accept;
    logic                   reject;
    logic                   last_push;
    logic                   hs;
    logic                   load;
    logic                   final_hs;

    ser_phase_e             phase;
    iq_sample_t             hold_q;
    logic                   hold_last;

    assign fifo_wdata = iq_pair_t'({i_in, q_in});
    assign start_ok   = (state == ST_IDLE) && start;
    assign accept     = (state == ST_CAPTURE) && in_valid && !fifo_full;
    assign reject     = (state == ST_CAPTURE) && in_valid && fifo_full;
    assign last_push  = accept && (wr_cnt == len_q - LEN_W'(1));

    // A Q handshake and the next pop share a cycle, so the stream has no bubble.
    assign hs       = out_valid && out_ready;
    assign load     = !fifo_empty && (!out_valid || (hs && phase == PH_Q));
    assign final_hs = hs && (phase == PH_Q) && out_last;
    assign busy     = (state != ST_IDLE);

    iq_sync_fifo #(
        .WIDTH ($bits(iq_pair_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .wdata (fifo_wdata),
        .pop   (load),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a latch behind.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) state_nxt = ST_CAPTURE;
                    else           done_nxt  = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (last_push) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (final_hs) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            done     <= 1'b0;
            len_q    <= '0;
            wr_cnt   <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (start_ok) begin
                len_q    <= len;
                wr_cnt   <= '0;
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else begin
                if (accept) wr_cnt <= wr_cnt + LEN_W'(1);
                if (reject) begin
                    overflow <= 1'b1;
                    if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Serializer: the holding register keeps the Q half while the I byte waits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase     <= PH_I;
            hold_q    <= '0;
            hold_last <= 1'b0;
            rd_cnt    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (start_ok) rd_cnt <= '0;
            if (load) begin
                hold_q    <= fifo_head.q;
                hold_last <= (rd_cnt == len_q - LEN_W'(1));
                rd_cnt    <= rd_cnt + LEN_W'(1);
                out_data  <= encode(fifo_head.i);
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                phase     <= PH_I;
            end else if (hs && phase == PH_I) begin
                out_data  <= encode(hold_q);
                out_last  <= hold_last;
                phase     <= PH_Q;
            end else if (hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                phase     <= PH_I;
            end
        end
    end

endmodule

// File: tb/tb_iq_byte_packer.sv
// Directed bench for iq_byte_packer: two instances share stimulus, one with a
// 4-bit drop counter so saturation is visible in the overflow scenario.
module tb_iq_byte_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [23:0] len = '0;
    logic        in_valid = 1'b0;
    logic [1:0]  i_in = '0;
    logic [1:0]  q_in = '0;
    logic        out_ready = 1'b0;

    logic [7:0]  out_data;
    logic        out_valid, out_last, busy, done, overflow;
    logic [15:0] drop_cnt;

    logic [7:0]  s_out_data;
    logic        s_out_valid, s_out_last, s_busy, s_done, s_overflow;
    logic [3:0]  s_drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iq_byte_packer #(.DEPTH(4), .LEN_W(24), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .i_in(i_in), .q_in(q_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    iq_byte_packer #(.DEPTH(4), .LEN_W(24), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .i_in(i_in), .q_in(q_in), .out_data(s_out_data), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_last(s_out_last), .busy(s_busy), .done(s_done),
        .overflow(s_overflow), .drop_cnt(s_drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte monitor on the falling edge: records handshakes, done pulses and
    // checks that a stalled byte is held until it is taken.
    logic [7:0] got_data [$];
    logic       got_last [$];
    int         cyc = 0;
    int         last_hs_cyc = -1;
    int         done_cyc = -1;
    int         done_pulses = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                if (out_last) last_hs_cyc = cyc;
            end
            if (done) begin
                done_pulses++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [23:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int k = 0;
        while (done_pulses == d0 && k < budget) begin
            tick();
            k++;
        end
        check(tag, done_pulses - d0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_drop"}, drop_cnt, 0);
    endtask

    logic [1:0] t1_i [3] = '{2'b10, 2'b11, 2'b01};
    logic [1:0] t1_q [3] = '{2'b01, 2'b00, 2'b11};
    logic [7:0] t1_b [6] = '{8'h02, 8'h01, 8'h03, 8'h00, 8'h01, 8'h03};

    logic [1:0] rr_i [6] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b11};
    logic [1:0] rr_q [6] = '{2'b10, 2'b01, 2'b00, 2'b11, 2'b11, 2'b01};
    logic [7:0] rr_b [12] = '{8'h01, 8'h02, 8'h02, 8'h01, 8'h03, 8'h00,
                              8'h00, 8'h03, 8'h02, 8'h03, 8'h03, 8'h01};

    logic [7:0] rs_b [4] = '{8'h02, 8'h03, 8'h01, 8'h00};

    initial begin
        int d0;
        int errs;
        int k;

        // Reset state
        #1;
        check_reset_outputs("rst");
        check("rst_sat_drop", s_drop_cnt, 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Basic record: three samples spaced four cycles apart
        out_ready = 1'b1;
        got_data.delete(); got_last.delete();
        d0 = done_pulses;
        pulse_start(24'd3);
        check("t1_busy_rise", busy, 1);
        for (int s = 0; s < 3; s++) begin
            i_in = t1_i[s]; q_in = t1_q[s]; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            repeat (3) tick();
        end
        wait_done("t1_done", d0, 50);
        check("t1_count", got_data.size(), 6);
        errs = 0;
        for (int b = 0; b < 6 && b < got_data.size(); b++) begin
            if (got_data[b] !== t1_b[b]) errs++;
            if (got_last[b] !== (b == 5)) errs++;
        end
        check("t1_bytes_last", errs, 0);
        check("t1_done_after_last", done_cyc - last_hs_cyc, 1);
        check("t1_ovf", overflow, 0);
        check("t1_busy_fall", busy, 0);

        // Zero-length capture: done next cycle, no bytes
        d0 = done_pulses;
        k = got_data.size();
        pulse_start(24'd0);
        check("z_done", done, 1);
        check("z_busy", busy, 0);
        check("z_valid", out_valid, 0);
        tick();
        check("z_done_fall", done, 0);
        check("z_bytes", got_data.size(), k);

        // Overflow: sink stalled 20 cycles while the front end strobes every cycle
        got_data.delete(); got_last.delete();
        d0 = done_pulses;
        out_ready = 1'b0;
        i_in = 2'b10; q_in = 2'b01;
        pulse_start(24'd10);
        in_valid = 1'b1;
        repeat (20) tick();
        // 5 samples held (4 in FIFO + 1 in serializer), edges 6..20 dropped
        check("ovf_drop_mid", drop_cnt, 15);
        check("ovf_flag_mid", overflow, 1);
        check("ovf_sat_mid", s_drop_cnt, 15);
        check("ovf_stall_valid", out_valid, 1);
        out_ready = 1'b1;
        repeat (12) tick();
        // Drain alternates pop/push; six more strobes hit a full FIFO
        start = 1'b1; len = 24'd5;
        tick();
        start = 1'b0;
        check("busy_start_drop", drop_cnt, 21);
        check("busy_start_ovf", overflow, 1);
        check("busy_start_busy", busy, 1);
        wait_done("ovf_done", d0, 100);
        in_valid = 1'b0;
        check("ovf_count", got_data.size(), 20);
        errs = 0;
        for (int b = 0; b < got_data.size(); b++) begin
            if (got_data[b] !== ((b % 2 == 0) ? 8'h02 : 8'h01)) errs++;
            if (got_last[b] !== (b == 19)) errs++;
        end
        check("ovf_bytes_last", errs, 0);
        check("ovf_drop_final", drop_cnt, 21);
        check("ovf_sat_final", s_drop_cnt, 15);
        check("ovf_sat_flag", s_overflow, 1);

        // Random sink backpressure
        got_data.delete(); got_last.delete();
        d0 = done_pulses;
        pulse_start(24'd6);
        check("rr_start_clears", drop_cnt, 0);
        for (int s = 0; s < 6; s++) begin
            i_in = rr_i[s]; q_in = rr_q[s]; in_valid = 1'b1;
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            in_valid = 1'b0;
            repeat (7) begin
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        k = 0;
        while (done_pulses == d0 && k < 200) begin
            out_ready = ($urandom_range(0, 1) != 0);
            tick();
            k++;
        end
        check("rr_done", done_pulses - d0, 1);
        check("rr_count", got_data.size(), 12);
        errs = 0;
        for (int b = 0; b < 12 && b < got_data.size(); b++) begin
            if (got_data[b] !== rr_b[b]) errs++;
            if (got_last[b] !== (b == 11)) errs++;
        end
        check("rr_order_last", errs, 0);
        check("rr_ovf", overflow, 0);

        // Reset in the middle of a drain
        out_ready = 1'b0;
        pulse_start(24'd2);
        i_in = 2'b11; q_in = 2'b01; in_valid = 1'b1;
        tick();
        i_in = 2'b00; q_in = 2'b10;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("mr_pre_valid", out_valid, 1);
        check("mr_pre_busy", busy, 1);
        d0 = done_pulses;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("mr");
        tick();
        rst = 1'b1;
        tick();
        check("mr_no_done", done_pulses - d0, 0);
        got_data.delete(); got_last.delete();
        out_ready = 1'b1;
        d0 = done_pulses;
        pulse_start(24'd2);
        i_in = 2'b10; q_in = 2'b11; in_valid = 1'b1;
        tick();
        i_in = 2'b01; q_in = 2'b00;
        tick();
        in_valid = 1'b0;
        wait_done("mr_done", d0, 50);
        check("mr_count", got_data.size(), 4);
        errs = 0;
        for (int b = 0; b < 4 && b < got_data.size(); b++) begin
            if (got_data[b] !== rs_b[b]) errs++;
            if (got_last[b] !== (b == 3)) errs++;
        end
        check("mr_bytes_last", errs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
